// File: rtl/alu_req_sequencer.sv
// Shared CPU operation encoding, plus the initiator-side ALU request sequencer.
// The sequencer issues tagged ops to one fixed-latency ALU and returns its results in issue order.
package cpu_defines_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7
    } alu_op_t;
endpackage

module alu_req_sequencer
    import cpu_defines_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned ALU_LAT    = 0,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  alu_op_t          req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output alu_op_t          alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);
    localparam int unsigned STAGES = ALU_LAT + 1;
    localparam int unsigned PTR_W  = $clog2(RESP_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned SUM_W  = CNT_W + 3;

    logic [WIDTH-1:0] alu_a_q, alu_b_q;
    alu_op_t          alu_op_q;

    logic [STAGES-1:0] pv_q;
    logic [TAG_W-1:0]  ptag_q [STAGES];

    logic [WIDTH-1:0] fres_q [RESP_DEPTH];
    logic             fzero_q [RESP_DEPTH];
    logic             fovf_q [RESP_DEPTH];
    logic [TAG_W-1:0] ftag_q [RESP_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] inflight_cnt, credit_used;
    logic             accept, push, pop;

    // Credit counts only current-cycle occupancy, so rsp_ready never reaches req_ready.
    always_comb begin
        inflight_cnt = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            inflight_cnt = inflight_cnt + SUM_W'(pv_q[i]);
        end
        credit_used = inflight_cnt + SUM_W'(cnt_q);
    end

    assign req_ready = credit_used < SUM_W'(RESP_DEPTH);
    assign accept    = req_valid && req_ready;
    assign push      = pv_q[STAGES-1];
    assign rsp_valid = cnt_q != '0;
    assign pop       = rsp_valid && rsp_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= ALU_ADD;
            pv_q     <= '0;
            for (int unsigned i = 0; i < STAGES; i++) ptag_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                alu_a_q  <= req_a;
                alu_b_q  <= req_b;
                alu_op_q <= req_op;
            end
            pv_q[0]   <= accept;
            ptag_q[0] <= req_tag;
            for (int unsigned i = 1; i < STAGES; i++) begin
                pv_q[i]   <= pv_q[i-1];
                ptag_q[i] <= ptag_q[i-1];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers and count alone decide what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            fres_q[wr_ptr_q]  <= alu_result;
            fzero_q[wr_ptr_q] <= alu_zero;
            fovf_q[wr_ptr_q]  <= alu_overflow;
            ftag_q[wr_ptr_q]  <= ptag_q[STAGES-1];
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign rsp_result   = rsp_valid ? fres_q[rd_ptr_q]  : '0;
    assign rsp_zero     = rsp_valid ? fzero_q[rd_ptr_q] : 1'b0;
    assign rsp_overflow = rsp_valid ? fovf_q[rd_ptr_q]  : 1'b0;
    assign rsp_tag      = rsp_valid ? ftag_q[rd_ptr_q]  : '0;
    assign busy         = (inflight_cnt != '0) || (cnt_q != '0);

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Self-checking bench for alu_req_sequencer with ALU_LAT=1, RESP_DEPTH=4 and a one-stage ALU model.
module tb_alu_req_sequencer;
    import cpu_defines_pkg::*;

    localparam int unsigned LAT   = 1;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_a, req_b;
    alu_op_t     req_op;
    logic [3:0]  req_tag;
    logic [31:0] alu_a, alu_b, alu_result;
    alu_op_t     alu_op;
    logic        alu_zero, alu_overflow;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_overflow;
    logic [3:0]  rsp_tag;
    logic        busy;

    alu_req_sequencer #(.WIDTH(32), .TAG_W(4), .ALU_LAT(LAT), .RESP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
        .rsp_tag(rsp_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {overflow, zero, result}.
    function automatic logic [33:0] alu_ref(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        o;
        o = 1'b0;
        case (op)
            ALU_ADD: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
            ALU_SUB: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SLT: r = {31'd0, $signed(a) < $signed(b)};
            ALU_SLL: r = a << b[4:0];
            ALU_SRL: r = a >> b[4:0];
            default: r = '0;
        endcase
        return {o, (r == 32'd0), r};
    endfunction

    logic [33:0] alu_q;
    always @(posedge clk) alu_q <= alu_ref(alu_op, alu_a, alu_b);
    assign alu_result   = alu_q[31:0];
    assign alu_zero     = alu_q[32];
    assign alu_overflow = alu_q[33];

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;
    logic [37:0] exp_q [$];
    int unsigned acc_cyc [$];
    int unsigned pop_cyc [$];
    int unsigned stall_total;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every pop is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'({rsp_tag, rsp_overflow, rsp_zero, rsp_result}), 64'(0));
            end else begin
                chk("rsp_data", 64'({rsp_tag, rsp_overflow, rsp_zero, rsp_result}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic send(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic [33:0] exp);
        int unsigned w = 0;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
        @(negedge clk);
        while (!req_ready && w < 40) begin
            w++;
            @(negedge clk);
        end
        if (!req_ready) chk("send_ready", 64'(req_ready), 64'(1));
        else begin
            exp_q.push_back({tag, exp});
            acc_cyc.push_back(cyc);
        end
        stall_total += w;
        @(posedge clk); #1;
    endtask

    task automatic idle_req();
        req_valid = 1'b0; req_a = 32'hDEAD_BEEF; req_b = 32'hCAFE_F00D; req_op = ALU_XOR; req_tag = 4'hF;
    endtask

    task automatic drain();
        int unsigned w = 0;
        rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && w < 60) begin
            @(posedge clk); #1;
            w++;
        end
        if (exp_q.size() != 0 || busy) chk("drain_done", 64'({exp_q.size() != 0, busy}), 64'(0));
    endtask

    typedef struct {
        alu_op_t     op;
        logic [31:0] a, b, res;
        logic        z, o;
    } vec_t;
    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned lat, acc;
        logic saw_valid;

        vecs[0] = '{ALU_ADD, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
        vecs[1] = '{ALU_ADD, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b1};
        vecs[2] = '{ALU_SUB, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0};
        vecs[3] = '{ALU_SUB, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b1};
        vecs[4] = '{ALU_AND, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0, 1'b0};
        vecs[5] = '{ALU_OR,  32'h1234_0000,  32'h0000_5678,  32'h1234_5678,  1'b0, 1'b0};
        vecs[6] = '{ALU_XOR, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0};
        vecs[7] = '{ALU_SUB, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0};

        rst_n = 1'b0; rsp_ready = 1'b0; stall_total = 0;
        idle_req();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_alu_ab", 64'({alu_a, alu_b}), 64'(0));
        chk("rst_alu_op", 64'(alu_op), 64'(0));
        chk("rst_rsp_data", 64'({rsp_tag, rsp_overflow, rsp_zero, rsp_result}), 64'(0));

        // Single op: response in cycle LAT+2 after the accept cycle.
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send(ALU_ADD, 32'd5, 32'd7, 4'd3, {1'b0, 1'b0, 32'd12});
        idle_req();
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk("single_busy", 64'(busy), 64'(1));
        end while (!rsp_valid && lat < 20);
        chk("single_latency", 64'(lat), 64'(LAT + 2));
        chk("alu_ab_hold", 64'({alu_a, alu_b}), {32'd5, 32'd7});
        @(posedge clk); #1;
        @(negedge clk);
        chk("single_busy_after", 64'({busy, rsp_valid}), 64'(0));

        // Table vectors back to back at full rate.
        @(posedge clk); #1;
        acc_cyc.delete(); pop_cyc.delete(); stall_total = 0;
        for (int i = 0; i < 8; i++) send(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i), {vecs[i].o, vecs[i].z, vecs[i].res});
        idle_req();
        drain();
        chk("full_rate_stalls", 64'(stall_total), 64'(0));
        chk("full_rate_pops", 64'(pop_cyc.size()), 64'(8));
        if (pop_cyc.size() == 8 && acc_cyc.size() == 8) begin
            chk("full_rate_first_lat", 64'(pop_cyc[0] - acc_cyc[0]), 64'(LAT + 2));
            chk("full_rate_span", 64'(pop_cyc[7] - pop_cyc[0]), 64'(7));
        end

        // Backpressure: exactly DEPTH accepts, then one re-open per pop.
        rsp_ready = 1'b0; acc = 0;
        for (int i = 0; i < 12; i++) begin
            req_valid = 1'b1; req_op = ALU_ADD; req_a = 32'(100 + acc); req_b = 32'(acc); req_tag = 4'(acc + 8);
            @(negedge clk);
            if (req_ready) begin
                exp_q.push_back({req_tag, alu_ref(req_op, req_a, req_b)});
                acc++;
            end
            @(posedge clk); #1;
        end
        idle_req();
        chk("bp_accepts", 64'(acc), 64'(DEPTH));
        @(negedge clk);
        chk("bp_ready_low", 64'(req_ready), 64'(0));
        chk("bp_busy", 64'(busy), 64'(1));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            @(negedge clk);
            chk("bp_reopen", 64'(req_ready), 64'(1));
            @(posedge clk); #1;
            send(ALU_SUB, 32'(50 + k), 32'd3, 4'(k + 1), alu_ref(ALU_SUB, 32'(50 + k), 32'd3));
            idle_req();
            @(negedge clk);
            chk("bp_full_again", 64'(req_ready), 64'(0));
        end
        @(posedge clk); #1;
        drain();

        // Three queued, then a pop/push stream across the pointer wrap.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(ALU_OR, 32'(i << 8), 32'(i), 4'(i + 4), alu_ref(ALU_OR, 32'(i << 8), 32'(i)));
        idle_req();
        repeat (LAT + 2) begin @(posedge clk); #1; end
        rsp_ready = 1'b1; stall_total = 0;
        for (int i = 0; i < 6; i++) send(ALU_XOR, 32'(i * 3), 32'h55, 4'(i + 10), alu_ref(ALU_XOR, 32'(i * 3), 32'h55));
        idle_req();
        chk("wrap_stalls", 64'(stall_total), 64'(0));
        drain();

        // Reset with ops in flight and queued: nothing stale may appear afterwards.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(ALU_ADD, 32'(i), 32'd1, 4'(i + 1), alu_ref(ALU_ADD, 32'(i), 32'd1));
        idle_req();
        exp_q.delete();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_alu_a", 64'(alu_a), 64'(0));
        rsp_ready = 1'b1; saw_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw_valid = saw_valid | rsp_valid;
        end
        chk("midrst_no_stale", 64'(saw_valid), 64'(0));
        @(posedge clk); #1;
        pop_cyc.delete();
        send(ALU_SUB, 32'd9, 32'd9, 4'd9, {1'b0, 1'b1, 32'd0});
        idle_req();
        drain();
        chk("midrst_next_pops", 64'(pop_cyc.size()), 64'(1));
        chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
